// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, IF/ID register and variable-latency imem handshake.
// Define IF_FETCH_PERF_COUNTERS_EN to build the stall/flush performance counters.
module if_fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcEnable,
    input  logic        ifEnable,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemRdata,
    output logic [31:0] instrID,
    output logic [31:0] pcPlus4ID,
    output logic        validID,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_id_q, pc_plus4_id_d;
    logic        valid_q, valid_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        req_q, req_d;

    logic        stall;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    assign stall    = ~(pcEnable & ifEnable);
    assign pc_plus4 = pc_q + 32'd4;
    assign target   = branchTarget & ~32'd3;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        pc_plus4_id_d = pc_plus4_id_q;
        valid_d       = valid_q;
        hold_buf_d    = hold_buf_q;
        redir_pc_d    = redir_pc_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imemReady) begin
                    if (branchTaken) begin
                        pc_d    = target;
                        valid_d = 1'b0;
                    end else if (stall) begin
                        hold_buf_d = imemRdata;
                        state_d    = HOLD;
                    end else begin
                        instr_d       = imemRdata;
                        pc_plus4_id_d = pc_plus4;
                        valid_d       = 1'b1;
                        pc_d          = pc_plus4;
                    end
                end else begin
                    if (branchTaken) begin
                        redir_pc_d = target;
                        valid_d    = 1'b0;
                        state_d    = DRAIN;
                    end else if (!stall) begin
                        valid_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (branchTaken) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!stall) begin
                    instr_d       = hold_buf_q;
                    pc_plus4_id_d = pc_plus4;
                    valid_d       = 1'b1;
                    pc_d          = pc_plus4;
                    state_d       = FETCH;
                end
            end
            DRAIN: begin
                // The abandoned request keeps pc on the old address until memory answers.
                valid_d = 1'b0;
                if (branchTaken) begin
                    redir_pc_d = target;
                end
                if (imemReady) begin
                    pc_d    = branchTaken ? target : redir_pc_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        req_d = (state_d == FETCH) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= PC_RESET;
            instr_q       <= 32'd0;
            pc_plus4_id_q <= 32'd0;
            valid_q       <= 1'b0;
            hold_buf_q    <= 32'd0;
            redir_pc_q    <= 32'd0;
            req_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            pc_plus4_id_q <= pc_plus4_id_d;
            valid_q       <= valid_d;
            hold_buf_q    <= hold_buf_d;
            redir_pc_q    <= redir_pc_d;
            req_q         <= req_d;
        end
    end

    assign imemReq   = req_q;
    assign imemAddr  = pc_q;
    assign instrID   = instr_q;
    assign pcPlus4ID = pc_plus4_id_q;
    assign validID   = valid_q;

`ifdef IF_FETCH_PERF_COUNTERS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (state_q != IDLE)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (branchTaken) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;
`else
    assign stallCount = 32'd0;
    assign flushCount = 32'd0;
`endif

endmodule
